// File: rtl/spi_host.sv
// Byte-wide SPI initiator: turns READ/WRITE/STREAM requests into target command
// sequences on sclk/cs/mosi and captures miso for reads. Resets the target first.
module spi_host #(
   parameter int CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [1:0] req_op,
   input  logic [4:0] req_addr,
   input  logic [7:0] req_data,
   output logic       rsp_valid,
   output logic [7:0] rsp_data,
   output logic       busy,
   output logic       spi_rst_n,
   output logic       sclk,
   output logic       cs,
   output logic [7:0] mosi,
   input  logic [7:0] miso
);

   localparam int HW = $clog2(CLK_DIV + 1);
   localparam logic [HW-1:0] HLAST = HW'(CLK_DIV - 1);
   localparam logic [HW-1:0] HONE  = HW'(1);

   localparam logic [1:0] OP_READ   = 2'b00;
   localparam logic [1:0] OP_WRITE  = 2'b01;
   localparam logic [1:0] OP_STREAM = 2'b10;
   localparam logic [1:0] OP_RSVD   = 2'b11;

   typedef enum logic [2:0] {INIT, IDLE, SETUP, HOLD, DONE, GAP} state_t;

   state_t        state, state_nx;
   logic [HW-1:0] hcnt, hcnt_nx;
   logic [1:0]    bcnt, bcnt_nx;
   logic          sclk_nx, cs_nx, spi_rst_n_nx, rsp_valid_nx;
   logic [7:0]    mosi_nx, rsp_data_nx;
   logic [1:0]    op_q;
   logic [4:0]    addr_q;
   logic [7:0]    data_q;

   // Byte k of the command sequence for a given op.
   function automatic logic [7:0] cmd_byte(input logic [1:0] op, input logic [4:0] addr,
                                           input logic [7:0] data, input logic [1:0] k);
      logic [7:0] b;
      b = data;
      if (k == 2'd0) begin
         case (op)
            OP_READ:  b = 8'h03;
            OP_WRITE: b = 8'h02;
            default:  b = 8'h80;
         endcase
      end else if (k == 2'd1 && op != OP_STREAM) begin
         b = {3'b000, addr};
      end
      return b;
   endfunction

   function automatic logic [1:0] last_byte(input logic [1:0] op);
      return (op == OP_WRITE) ? 2'd2 : 2'd1;
   endfunction

   assign req_ready = (state == IDLE);
   assign busy      = (state != IDLE);

   always_ff @(posedge clk) begin
      if (state == IDLE && req_valid) begin
         op_q   <= req_op;
         addr_q <= req_addr;
         data_q <= req_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= INIT;
         hcnt      <= '0;
         bcnt      <= '0;
         sclk      <= 1'b0;
         cs        <= 1'b0;
         mosi      <= 8'h00;
         spi_rst_n <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_data  <= 8'h00;
      end else begin
         state     <= state_nx;
         hcnt      <= hcnt_nx;
         bcnt      <= bcnt_nx;
         sclk      <= sclk_nx;
         cs        <= cs_nx;
         mosi      <= mosi_nx;
         spi_rst_n <= spi_rst_n_nx;
         rsp_valid <= rsp_valid_nx;
         rsp_data  <= rsp_data_nx;
      end
   end

   always_comb begin
      state_nx     = state;
      hcnt_nx      = hcnt;
      bcnt_nx      = bcnt;
      sclk_nx      = sclk;
      cs_nx        = cs;
      mosi_nx      = mosi;
      spi_rst_n_nx = spi_rst_n;
      rsp_valid_nx = 1'b0;
      rsp_data_nx  = rsp_data;
      case (state)
         INIT: begin
            // Two full sclk pulses with the target held in reset.
            if (hcnt == HLAST) begin
               hcnt_nx = '0;
               sclk_nx = ~sclk;
               if (sclk) begin
                  bcnt_nx = bcnt + 2'd1;
                  if (bcnt == 2'd1) begin
                     state_nx     = IDLE;
                     spi_rst_n_nx = 1'b1;
                     bcnt_nx      = '0;
                  end
               end
            end else begin
               hcnt_nx = hcnt + HONE;
            end
         end
         IDLE: begin
            if (req_valid) begin
               hcnt_nx = '0;
               bcnt_nx = '0;
               if (req_op == OP_RSVD) begin
                  state_nx     = DONE;
                  rsp_valid_nx = 1'b1;
                  rsp_data_nx  = 8'h00;
               end else begin
                  state_nx = SETUP;
                  cs_nx    = 1'b1;
                  mosi_nx  = cmd_byte(req_op, req_addr, req_data, 2'd0);
               end
            end
         end
         SETUP: begin
            if (hcnt == HLAST) begin
               hcnt_nx  = '0;
               sclk_nx  = 1'b1;
               state_nx = HOLD;
            end else begin
               hcnt_nx = hcnt + HONE;
            end
         end
         HOLD: begin
            // mosi only moves on the falling edge, so the target never sees it change while sclk=1.
            if (hcnt == HLAST) begin
               hcnt_nx = '0;
               sclk_nx = 1'b0;
               if (bcnt == last_byte(op_q)) begin
                  state_nx     = DONE;
                  cs_nx        = 1'b0;
                  mosi_nx      = 8'h00;
                  rsp_valid_nx = 1'b1;
                  rsp_data_nx  = (op_q == OP_READ) ? miso : 8'h00;
               end else begin
                  bcnt_nx  = bcnt + 2'd1;
                  mosi_nx  = cmd_byte(op_q, addr_q, data_q, bcnt + 2'd1);
                  state_nx = SETUP;
               end
            end else begin
               hcnt_nx = hcnt + HONE;
            end
         end
         DONE: begin
            hcnt_nx  = HONE;
            state_nx = (op_q == OP_RSVD || CLK_DIV == 1) ? IDLE : GAP;
         end
         GAP: begin
            if (hcnt == HLAST) begin
               hcnt_nx  = '0;
               state_nx = IDLE;
            end else begin
               hcnt_nx = hcnt + HONE;
            end
         end
         default: state_nx = INIT;
      endcase
   end

endmodule

// File: tb/tb_spi_host.sv
// Bench for spi_host: two hosts (CLK_DIV=4 and 1), each driving a behavioural SPI target,
// with a cycle-level reference model checked on every falling clock edge.
module tb_spi_host;

   localparam int CD0 = 4;
   localparam int CD1 = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   logic       rv0, rr0, rsv0, busy0, srst0, sclk0, cs0;
   logic [1:0] op0;
   logic [4:0] ad0;
   logic [7:0] dt0, rsd0, mosi0, miso0;
   logic       rv1, rr1, rsv1, busy1, srst1, sclk1, cs1;
   logic [1:0] op1;
   logic [4:0] ad1;
   logic [7:0] dt1, rsd1, mosi1, miso1;

   spi_host #(.CLK_DIV(CD0)) dut0 (
      .clk(clk), .rst_n(rst_n), .req_valid(rv0), .req_ready(rr0), .req_op(op0),
      .req_addr(ad0), .req_data(dt0), .rsp_valid(rsv0), .rsp_data(rsd0), .busy(busy0),
      .spi_rst_n(srst0), .sclk(sclk0), .cs(cs0), .mosi(mosi0), .miso(miso0));

   spi_host #(.CLK_DIV(CD1)) dut1 (
      .clk(clk), .rst_n(rst_n), .req_valid(rv1), .req_ready(rr1), .req_op(op1),
      .req_addr(ad1), .req_data(dt1), .rsp_valid(rsv1), .rsp_data(rsd1), .busy(busy1),
      .spi_rst_n(srst1), .sclk(sclk1), .cs(cs1), .mosi(mosi1), .miso(miso1));

   int checks = 0;
   int passes = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // ---------------- behavioural SPI target ----------------
   // 16 memory bytes: 0..7 masks, 8..15 characters; address bit 4 selects the result register.
   logic [7:0] tmem [2][16];
   logic [7:0] tres [2];
   logic [7:0] tcmd [2];
   logic [7:0] tmiso [2];
   int         tcnt [2];
   int         trises [2];
   logic [7:0] tlog0 [$];
   logic [7:0] tlog1 [$];

   assign miso0 = tmiso[0];
   assign miso1 = tmiso[1];

   task automatic tgt_rise(input int i, input logic srst, input logic c, input logic [7:0] m);
      logic [7:0] a;
      trises[i]++;
      if (!srst) begin
         tcnt[i] = 0;
         return;
      end
      if (!c) return;
      if (i == 0) tlog0.push_back(m);
      else tlog1.push_back(m);
      case (tcnt[i])
         0: tcmd[i] = m;
         1: begin
            if (tcmd[i] == 8'h03) begin
               tmiso[i] = m[4] ? tres[i] : tmem[i][m[3:0]];
            end else if (tcmd[i] == 8'h80) begin
               for (int k = 0; k < 8; k++)
                  if (tmem[i][8+k] == m) tres[i] = tres[i] | tmem[i][k];
            end else if (tcmd[i] == 8'h02) begin
               tmiso[i] = m;
            end
         end
         2: begin
            if (tcmd[i] == 8'h02) begin
               a = tmiso[i];
               if (a[4]) tres[i] = m;
               else tmem[i][a[3:0]] = m;
            end
         end
         default: ;
      endcase
      tcnt[i]++;
   endtask

   always @(posedge sclk0) tgt_rise(0, srst0, cs0, mosi0);
   always @(posedge sclk1) tgt_rise(1, srst1, cs1, mosi1);
   always @(negedge cs0) tcnt[0] = 0;
   always @(negedge cs1) tcnt[1] = 0;

   // ---------------- reference model ----------------
   int         mc [2];
   int         mt [2];
   int         mop [2];
   logic [4:0] maddr [2];
   logic [7:0] mdata [2];
   logic [7:0] m_rd [2];
   logic [7:0] sb_mem [2][16];
   logic [7:0] sb_res [2];

   function automatic int nbytes(input int op);
      return (op == 1) ? 3 : (op == 3) ? 0 : 2;
   endfunction

   function automatic logic [7:0] exp_byte(input int op, input logic [4:0] a, input logic [7:0] d, input int k);
      if (k == 0) return (op == 0) ? 8'h03 : (op == 1) ? 8'h02 : 8'h80;
      if (k == 1 && op != 2) return {3'b000, a};
      return d;
   endfunction

   function automatic logic [7:0] sb_apply(input int i, input int op, input logic [4:0] a, input logic [7:0] d);
      logic [7:0] r;
      r = 8'h00;
      case (op)
         0: r = a[4] ? sb_res[i] : sb_mem[i][a[3:0]];
         1: if (a[4]) sb_res[i] = d; else sb_mem[i][a[3:0]] = d;
         2: for (int k = 0; k < 8; k++)
               if (sb_mem[i][8+k] == d) sb_res[i] = sb_res[i] | sb_mem[i][k];
         default: ;
      endcase
      return r;
   endfunction

   task automatic model_step(input int i, input int cd, input logic rstn, input logic rv,
                             input logic [1:0] op, input logic [4:0] a, input logic [7:0] d,
                             input logic [21:0] act);
      logic e_sclk, e_cs, e_srst, e_rdy, e_busy, e_rv;
      logic [7:0] e_mosi;
      int c, n, endc, rdyc, dd;
      e_sclk = 0; e_cs = 0; e_srst = 0; e_rdy = 0; e_busy = 1; e_rv = 0; e_mosi = 8'h00;
      n = 0; endc = -1; rdyc = -1;
      c = mc[i];
      if (!rstn) begin
         m_rd[i] = 8'h00;
         mc[i] = 0;
         mt[i] = -1;
      end else begin
         if (c < 4 * cd) begin
            e_sclk = ((c / cd) % 2) == 1;
         end else begin
            e_srst = 1;
            if (mt[i] >= 0) begin
               n    = nbytes(mop[i]);
               endc = (mop[i] == 3) ? mt[i] + 1 : mt[i] + 1 + 2 * n * cd;
               rdyc = (mop[i] == 3) ? mt[i] + 2 : endc + cd;
               if (c >= rdyc) mt[i] = -1;
            end
            if (mt[i] < 0) begin
               e_rdy  = 1;
               e_busy = 0;
            end else begin
               dd = c - mt[i] - 1;
               if (mop[i] != 3 && dd < 2 * n * cd) begin
                  e_cs   = 1;
                  e_mosi = exp_byte(mop[i], maddr[i], mdata[i], dd / (2 * cd));
                  e_sclk = (dd % (2 * cd)) >= cd;
               end
               if (c == endc) begin
                  e_rv    = 1;
                  m_rd[i] = sb_apply(i, mop[i], maddr[i], mdata[i]);
               end
            end
         end
      end
      chk($sformatf("dut%0d cyc%0d {sclk,cs,mosi,srst,rdy,busy,rv,rd}", i, c), 32'(act),
          32'({e_sclk, e_cs, e_mosi, e_srst, e_rdy, e_busy, e_rv, m_rd[i]}));
      if (rstn) begin
         if (e_rdy && rv) begin
            mt[i]    = c;
            mop[i]   = int'(op);
            maddr[i] = a;
            mdata[i] = d;
         end
         mc[i] = c + 1;
      end
   endtask

   always @(negedge clk) begin
      model_step(0, CD0, rst_n, rv0, op0, ad0, dt0, {sclk0, cs0, mosi0, srst0, rr0, busy0, rsv0, rsd0});
      model_step(1, CD1, rst_n, rv1, op1, ad1, dt1, {sclk1, cs1, mosi1, srst1, rr1, busy1, rsv1, rsd1});
   end

   // ---------------- stimulus helpers ----------------
   task automatic drive(input int i, input logic v, input logic [1:0] op, input logic [4:0] a, input logic [7:0] d);
      if (i == 0) begin rv0 = v; op0 = op; ad0 = a; dt0 = d; end
      else begin rv1 = v; op1 = op; ad1 = a; dt1 = d; end
   endtask

   function automatic logic ready_of(input int i);
      return (i == 0) ? rr0 : rr1;
   endfunction

   function automatic logic rsv_of(input int i);
      return (i == 0) ? rsv0 : rsv1;
   endfunction

   function automatic logic [7:0] rsd_of(input int i);
      return (i == 0) ? rsd0 : rsd1;
   endfunction

   function automatic logic [31:0] pack_log(input int i);
      logic [31:0] r;
      r = 32'h0;
      if (i == 0) foreach (tlog0[k]) r = {r[23:0], tlog0[k]};
      else foreach (tlog1[k]) r = {r[23:0], tlog1[k]};
      return r;
   endfunction

   // Returns response latency and ready latency, both in cycles after the handshake cycle.
   task automatic do_op(input int i, input logic [1:0] op, input logic [4:0] a, input logic [7:0] d,
                        output int lrsp, output int lrdy, output logic [7:0] rd);
      int k;
      lrsp = -1; lrdy = -1; rd = 8'hxx;
      @(posedge clk);
      #1;
      if (i == 0) tlog0.delete(); else tlog1.delete();
      trises[i] = 0;
      drive(i, 1'b1, op, a, d);
      k = 0;
      @(negedge clk);
      while (!ready_of(i) && k < 200) begin
         @(negedge clk);
         k++;
      end
      if (!ready_of(i)) begin
         chk($sformatf("dut%0d handshake", i), 32'(ready_of(i)), 32'd1);
         drive(i, 1'b0, 2'b00, 5'h00, 8'h00);
         return;
      end
      @(posedge clk);
      #1;
      drive(i, 1'b0, 2'b00, 5'h00, 8'h00);
      for (k = 1; k < 200; k++) begin
         @(negedge clk);
         if (rsv_of(i)) begin
            lrsp = k;
            rd   = rsd_of(i);
         end
         if (lrsp >= 0 && ready_of(i)) begin
            lrdy = k;
            break;
         end
      end
   endtask

   task automatic wait_init(input string tag);
      int k0, k1;
      k0 = -1; k1 = -1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (rr0 && k0 < 0) k0 = k;
         if (rr1 && k1 < 0) k1 = k;
         if (k0 >= 0 && k1 >= 0) break;
      end
      chk({tag, " dut0 ready cycle"}, 32'(k0), 32'd16);
      chk({tag, " dut1 ready cycle"}, 32'(k1), 32'd4);
      chk({tag, " dut0 init pulses"}, 32'(trises[0]), 32'd2);
      chk({tag, " dut0 spi_rst_n"}, 32'(srst0), 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int lrsp, lrdy, hs, rsps, k;
      logic [7:0] rd;
      rst_n = 1'b0;
      drive(0, 1'b0, 2'b00, 5'h00, 8'h00);
      drive(1, 1'b0, 2'b00, 5'h00, 8'h00);
      for (int i = 0; i < 2; i++) begin
         for (int j = 0; j < 16; j++) begin
            tmem[i][j]   = 8'h00;
            sb_mem[i][j] = 8'h00;
         end
         tres[i] = 8'h00; sb_res[i] = 8'h00; tcmd[i] = 8'h00; tmiso[i] = 8'h00;
         tcnt[i] = 0; mc[i] = 0; mt[i] = -1; m_rd[i] = 8'h00; mop[i] = 0;
         maddr[i] = 5'h00; mdata[i] = 8'h00;
      end
      repeat (3) @(posedge clk);
      #1;
      chk("reset busy", 32'(busy0), 32'd1);
      chk("reset ready", 32'(rr0), 32'd0);
      trises[0] = 0; trises[1] = 0;
      rst_n = 1'b1;
      wait_init("boot");

      // WRITE mem[3]=A5
      do_op(0, 2'b01, 5'h03, 8'hA5, lrsp, lrdy, rd);
      chk("write rsp latency", 32'(lrsp), 32'd25);
      chk("write ready latency", 32'(lrdy), 32'd29);
      chk("write rsp_data", 32'(rd), 32'h00);
      chk("write mosi bytes", pack_log(0), 32'h0002_03A5);
      chk("write sclk rises", 32'(trises[0]), 32'd3);
      chk("target mem3", 32'(tmem[0][3]), 32'hA5);

      do_op(0, 2'b00, 5'h03, 8'h00, lrsp, lrdy, rd);
      chk("read rsp latency", 32'(lrsp), 32'd17);
      chk("read3 data", 32'(rd), 32'hA5);
      chk("read mosi bytes", pack_log(0), 32'h0000_0303);
      do_op(0, 2'b00, 5'h10, 8'h00, lrsp, lrdy, rd);
      chk("read result initial", 32'(rd), 32'h00);

      // Character/mask match through STREAM
      do_op(0, 2'b01, 5'h0A, 8'h41, lrsp, lrdy, rd);
      do_op(0, 2'b01, 5'h02, 8'h0F, lrsp, lrdy, rd);
      do_op(0, 2'b01, 5'h10, 8'h00, lrsp, lrdy, rd);
      do_op(0, 2'b10, 5'h00, 8'h41, lrsp, lrdy, rd);
      chk("stream mosi bytes", pack_log(0), 32'h0000_8041);
      chk("stream rsp latency", 32'(lrsp), 32'd17);
      do_op(0, 2'b00, 5'h10, 8'h00, lrsp, lrdy, rd);
      chk("read result after stream", 32'(rd), 32'h0F);

      // Reserved op: no SPI activity, zero data
      do_op(0, 2'b11, 5'h03, 8'h55, lrsp, lrdy, rd);
      chk("rsvd rsp latency", 32'(lrsp), 32'd1);
      chk("rsvd ready latency", 32'(lrdy), 32'd2);
      chk("rsvd rsp_data", 32'(rd), 32'h00);
      chk("rsvd sclk rises", 32'(trises[0]), 32'd0);

      // req_valid held high across three back-to-back ops
      @(posedge clk);
      #1;
      trises[0] = 0;
      drive(0, 1'b1, 2'b01, 5'h05, 8'h5A);
      hs = 0; rsps = 0; rd = 8'h00;
      for (k = 0; k < 300; k++) begin
         @(negedge clk);
         if (rsv0) begin
            rsps++;
            rd = rsd0;
         end
         if (rsps == 3 && rr0) break;
         if (rr0 && rv0) begin
            hs++;
            @(posedge clk);
            #1;
            if (hs == 1) drive(0, 1'b1, 2'b01, 5'h06, 8'h66);
            else if (hs == 2) drive(0, 1'b1, 2'b00, 5'h05, 8'h00);
            else drive(0, 1'b0, 2'b00, 5'h00, 8'h00);
         end
      end
      chk("held valid handshakes", 32'(hs), 32'd3);
      chk("held valid responses", 32'(rsps), 32'd3);
      chk("held valid read data", 32'(rd), 32'h5A);
      chk("held valid sclk rises", 32'(trises[0]), 32'd8);
      chk("held valid mem6", 32'(tmem[0][6]), 32'h66);

      // Async reset while sclk=1 in byte 1 of a WRITE
      @(posedge clk);
      #1;
      drive(0, 1'b1, 2'b01, 5'h03, 8'h77);
      @(posedge clk);
      #1;
      drive(0, 1'b0, 2'b00, 5'h00, 8'h00);
      repeat (12) @(posedge clk);
      #1;
      chk("pre-reset sclk high", 32'(sclk0), 32'd1);
      chk("pre-reset cs", 32'(cs0), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort sclk", 32'(sclk0), 32'd0);
      chk("abort cs", 32'(cs0), 32'd0);
      chk("abort mosi", 32'(mosi0), 32'h00);
      repeat (3) @(posedge clk);
      #1;
      trises[0] = 0;
      rst_n = 1'b1;
      wait_init("post-abort");
      do_op(0, 2'b00, 5'h03, 8'h00, lrsp, lrdy, rd);
      chk("read3 after abort", 32'(rd), 32'hA5);

      // CLK_DIV=1 round trip
      do_op(1, 2'b01, 5'h07, 8'h3C, lrsp, lrdy, rd);
      chk("div1 write rsp latency", 32'(lrsp), 32'd7);
      chk("div1 write ready latency", 32'(lrdy), 32'd8);
      chk("div1 mosi bytes", pack_log(1), 32'h0002_073C);
      do_op(1, 2'b00, 5'h07, 8'h00, lrsp, lrdy, rd);
      chk("div1 read rsp latency", 32'(lrsp), 32'd5);
      chk("div1 read data", 32'(rd), 32'h3C);

      repeat (4) @(posedge clk);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
